keypad_scan_ctrl: RTL

//  Active scan controller for the 4x4 Pmod keypad on JA. Drives one column low at a time, samples the

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_scan_ctrl_if.sv | 11 +
 rtl/keypad_scan_ctrl_sync2.sv | 19 +
 rtl/keypad_scan_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, key encoding and scan state type for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned NUM_KEYS = 16;

   // bit 4 set means "no key"; bits 3:0 hold row*4+col otherwise
   typedef logic [4:0] key_t;
   localparam key_t KEY_NONE = 5'h10;

   typedef enum logic {DRIVE, EVAL} scan_state_t;

   function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Debounced key bus from the keypad scanner to the game logic.
interface keypad_scan_ctrl_if;
   logic [15:0] key_onehot;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        press_pulse;
   logic        release_pulse;

   modport master (output key_onehot, key_code, key_valid, press_pulse, release_pulse);
   modport slave  (input  key_onehot, key_code, key_valid, press_pulse, release_pulse);
endinterface

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous active-low row inputs.
module sync2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);
   logic [3:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning 4x4 keypad controller with multi-press rejection and scan-level debounce.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                clk,
   input  logic                rst,
   output logic [3:0]          col_n,
   input  logic [3:0]          row_n,
   keypad_scan_ctrl_if.master  key
);
   localparam int unsigned CW = $clog2(SETTLE_CYCLES);
   localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_SCANS);
   localparam logic [1:0]    COL_LAST = 2'(NUM_COLS - 1);

   scan_state_t   state;
   logic [1:0]    col;
   logic [CW-1:0] cnt;
   logic [15:0]   scan_bits;
   logic [15:0]   col_hits;
   key_t          prev;
   key_t          held;
   key_t          result;
   logic [DW-1:0] dcnt;
   logic [DW-1:0] dcnt_next;
   logic [3:0]    rows_sync;
   logic [4:0]    nbits;
   logic [3:0]    idx;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_n),
      .q   (rows_sync)
   );

   always_comb begin
      col_hits = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++)
         col_hits[key_index(2'(r), col)] = ~rows_sync[r];
   end

   // Exactly one bit set resolves to a key; ghosting/multi-press resolves to none.
   always_comb begin
      nbits  = '0;
      idx    = '0;
      result = KEY_NONE;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (scan_bits[i]) begin
            nbits = nbits + 5'd1;
            idx   = 4'(i);
         end
      end
      if (nbits == 5'd1)
         result = {1'b0, idx};
   end

   always_comb begin
      if (result == prev)
         dcnt_next = (dcnt == DCNT_MAX) ? dcnt : dcnt + DW'(1);
      else
         dcnt_next = DW'(1);
   end

   // col_n is registered with the value for the state being entered, so it lines up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= DRIVE;
         col               <= '0;
         cnt               <= '0;
         col_n             <= 4'b1111;
         scan_bits         <= '0;
         prev              <= KEY_NONE;
         held              <= KEY_NONE;
         dcnt              <= '0;
         key.key_onehot    <= '0;
         key.key_code      <= '0;
         key.key_valid     <= 1'b0;
         key.press_pulse   <= 1'b0;
         key.release_pulse <= 1'b0;
      end else begin
         key.press_pulse   <= 1'b0;
         key.release_pulse <= 1'b0;
         case (state)
            DRIVE: begin
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  scan_bits <= scan_bits | col_hits;
                  if (col == COL_LAST) begin
                     state <= EVAL;
                     col_n <= 4'b1111;
                  end else begin
                     col   <= col + 2'd1;
                     col_n <= ~(4'b0001 << (col + 2'd1));
                  end
               end else begin
                  cnt   <= cnt + CW'(1);
                  col_n <= ~(4'b0001 << col);
               end
            end
            EVAL: begin
               state     <= DRIVE;
               scan_bits <= '0;
               col       <= '0;
               col_n     <= 4'b1110;
               dcnt      <= dcnt_next;
               prev      <= result;
               if (dcnt_next == DCNT_MAX && result != held) begin
                  held              <= result;
                  key.press_pulse   <= ~result[4];
                  key.release_pulse <= ~held[4];
                  key.key_valid     <= ~result[4];
                  key.key_code      <= result[4] ? 4'd0 : result[3:0];
                  key.key_onehot    <= result[4] ? 16'h0000 : (16'h0001 << result[3:0]);
               end
            end
            default: state <= DRIVE;
         endcase
      end
   end
endmodule
